// File: rtl/clm_job_sched_pkg.sv
// clm_job_sched_pkg: shared state encoding, default sizes and the random-operand array type
package clm_job_sched_pkg;
    localparam int CLM_D = 8;
    localparam int CLM_NRAND = 23;
    localparam int CLM_TMO = 1023;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
    typedef logic [CLM_NRAND-1:0][CLM_D-1:0] core_r_t;
endpackage

// File: rtl/clm_job_sched_if.sv
// clm_job_sched_if: two-requester job request / response bundle
interface clm_job_sched_if;
    logic [1:0] req_vld, req_rdy, rsp_vld;
    logic [1:0][127:0] req_pt, req_key;
    logic [1:0][4:0] req_p;
    logic [127:0] rsp_ct;
    logic rsp_err;
    modport master (output req_vld, req_pt, req_key, req_p, input req_rdy, rsp_vld, rsp_ct, rsp_err);
    modport slave (input req_vld, req_pt, req_key, req_p, output req_rdy, rsp_vld, rsp_ct, rsp_err);
endinterface

// File: rtl/clm_rr_arb2.sv
// clm_rr_arb2: two-way round-robin arbiter, pointer advances only on a taken grant
module clm_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic ptr;
    always_comb gnt = &req ? (ptr ? 2'b10 : 2'b01) : (req[0] ? 2'b01 : {req[1], 1'b0});
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 1'b0;
        else if (en && |gnt) ptr <= gnt[0];
endmodule

// File: rtl/clm_job_sched.sv
// clm_job_sched: arbitrates two requesters onto one CLM core, loads fresh randomness, runs with timeout
module clm_job_sched import clm_job_sched_pkg::*; #(
    parameter int D = CLM_D,
    parameter int NRAND = CLM_NRAND,
    parameter int TMO = CLM_TMO
) (
    input  logic                       clk,
    input  logic                       rst,
    clm_job_sched_if.slave             bus,
    input  logic                       rnd_vld,
    output logic                       rnd_rdy,
    input  logic [D-1:0]               rnd_data,
    output logic [127:0]               core_pt,
    output logic [127:0]               core_key,
    output logic [4:0]                 core_p,
    output logic [NRAND-1:0][D-1:0]    core_r,
    output logic                       core_start,
    input  logic                       core_done,
    input  logic [127:0]               core_ct
);
    localparam int IW = $clog2(NRAND);
    localparam int CW = $clog2(TMO + 1);
    state_t state, state_n;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [1:0] gnt;
    logic own, grant, hs, last, tmo, fin, err_q;
    logic [127:0] ct_q;
    clm_rr_arb2 u_arb (.clk(clk), .rst(rst), .req(bus.req_vld), .en(state == IDLE), .gnt(gnt));
    assign grant = state == IDLE && |gnt;
    assign hs = rnd_vld && state == LOAD;
    assign last = hs && idx == IW'(NRAND - 1);
    // cnt counts completed RUN cycles, so the timeout fires in the TMO-th RUN cycle
    assign tmo = cnt == CW'(TMO - 1);
    assign fin = core_done || tmo;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = grant ? LOAD : IDLE;
            LOAD: state_n = last ? RUN : LOAD;
            RUN: state_n = fin ? RESP : RUN;
            default: state_n = IDLE;
        endcase
        rnd_rdy = state == LOAD;
        core_start = state == RUN;
        bus.req_rdy = (state == IDLE && !rst) ? gnt : 2'b00;
        bus.rsp_vld = state == RESP ? {own, !own} : 2'b00;
        bus.rsp_ct = ct_q;
        bus.rsp_err = err_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            core_pt <= '0;
            core_key <= '0;
            core_p <= '0;
            core_r <= '0;
            own <= 1'b0;
            idx <= '0;
            cnt <= '0;
            ct_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant) begin
                core_pt <= bus.req_pt[gnt[1]];
                core_key <= bus.req_key[gnt[1]];
                core_p <= bus.req_p[gnt[1]];
                own <= gnt[1];
            end
            if (hs) begin
                core_r[idx] <= rnd_data;
                idx <= last ? '0 : idx + IW'(1);
            end
            if (state == RUN) begin
                cnt <= fin ? '0 : cnt + CW'(1);
                if (fin) begin
                    ct_q <= core_done ? core_ct : '0;
                    err_q <= !core_done;
                end
            end
        end
endmodule
